platform_map: RTL and testbench

PLATFORM_MAP -- requirements
Module: platform_map

---
 rtl/platform_map_if.sv | 25 ++
 rtl/platform_map.sv | 195 +++++++++++++++++++
 tb/tb_platform_map.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/platform_map_if.sv
// Raster/mask bus between the video timing source and the platform map renderer.
interface platform_map_if #(
  parameter int unsigned NUM_ROWS = 6
);
  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic [9:0]          hcount;
  logic [9:0]          vcount;
  logic                bounds_draw;
  logic [NUM_ROWS-1:0] mask_data;
  logic                mask_load;
  logic                mask_pending;
  logic                tile_draw;
  logic [ROW_W-1:0]    tile_row;

  modport master (
    output hcount, vcount, bounds_draw, mask_data, mask_load,
    input  mask_pending, tile_draw, tile_row
  );

  modport slave (
    input  hcount, vcount, bounds_draw, mask_data, mask_load,
    output mask_pending, tile_draw, tile_row
  );
endinterface

// File: rtl/platform_map.sv
// Girder-style platform row renderer with frame-synchronous row mask.
// Define MAP_SLOPE_EN to tilt girders (even rows descend rightwards, odd rows ascend).
module platform_map #(
  parameter int unsigned NUM_ROWS    = 6,
  parameter int unsigned FIRST_ROW_V = 250,
  parameter int unsigned ROW_PITCH   = 40,
  parameter int unsigned ROW_HEIGHT  = 10,
  parameter int unsigned TILE_W      = 16,
  parameter int unsigned H_START     = 150,
  parameter int unsigned H_END       = 630,
  parameter int unsigned SLOPE_STEP  = 64,
  parameter int unsigned SLOPE_MAX   = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  platform_map_if.slave  bus
);

`ifdef MAP_SLOPE_EN
  localparam int unsigned BAND_H = ROW_HEIGHT + SLOPE_MAX;
`else
  localparam int unsigned BAND_H = ROW_HEIGHT;
`endif
  localparam int unsigned GAP_N  = ROW_PITCH - BAND_H;
  localparam int unsigned TY_W   = $clog2(ROW_PITCH + 1);
  localparam int unsigned ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned TX_W   = $clog2(TILE_W);
  localparam int unsigned CW     = 11;

  if (ROW_PITCH < ROW_HEIGHT + SLOPE_MAX + 1 || SLOPE_STEP == 0) begin : g_bad_cfg
    $error("platform_map: ROW_PITCH must exceed ROW_HEIGHT+SLOPE_MAX and SLOPE_STEP must be nonzero");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BAND, ST_GAP, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [TY_W-1:0]     ty_q, ty_d;
  logic                synced_q, synced_d;
  logic [NUM_ROWS-1:0] shadow_q, shadow_d;
  logic [NUM_ROWS-1:0] active_q, active_d;
  logic                pend_q, pend_d;
  logic                s1_draw_q, s1_draw_d;
  logic [ROW_W-1:0]    s1_row_q, s1_row_d;
  logic                draw_q, draw_d;
  logic [ROW_W-1:0]    row_out_q, row_out_d;

  logic                line_start_c;
  logic                frame_start_c;
  logic                in_win_c;
  logic [CW-1:0]       tx_c;
  logic [CW-1:0]       ty_eff_c;
  logic                ty_ok_c;
  logic                pat_c;

  assign line_start_c  = (bus.hcount == 10'd0);
  assign frame_start_c = line_start_c && (bus.vcount == 10'd0);

`ifdef MAP_SLOPE_EN
  localparam int unsigned SS_W  = $clog2(SLOPE_STEP + 1);
  localparam int unsigned OFF_W = $clog2(SLOPE_MAX + 1);

  logic [SS_W-1:0]  sub_q, sub_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [SS_W-1:0]  cur_sub_c;
  logic [OFF_W-1:0] cur_off_c;
  logic [OFF_W-1:0] row_off_c;

  // Offset counter restarts at the left edge of the drawn window.
  always_comb begin
    cur_sub_c = (bus.hcount == 10'(H_START)) ? '0 : sub_q;
    cur_off_c = (bus.hcount == 10'(H_START)) ? '0 : off_q;
    sub_d     = cur_sub_c + SS_W'(1);
    off_d     = cur_off_c;
    if (cur_sub_c == SS_W'(SLOPE_STEP - 1)) begin
      sub_d = '0;
      off_d = (cur_off_c == OFF_W'(SLOPE_MAX)) ? cur_off_c : cur_off_c + OFF_W'(1);
    end
    row_off_c = row_q[0] ? OFF_W'(SLOPE_MAX) - cur_off_c : cur_off_c;
    ty_eff_c  = CW'(ty_q) - CW'(row_off_c);
    ty_ok_c   = (CW'(ty_q) >= CW'(row_off_c)) && (ty_eff_c < CW'(ROW_HEIGHT));
  end
`else
  always_comb begin
    ty_eff_c = CW'(ty_q);
    ty_ok_c  = (ty_eff_c < CW'(ROW_HEIGHT));
  end
`endif

  // Vertical tracker: advances once per line on the hcount==0 cycle.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    ty_d     = ty_q;
    synced_d = synced_q;
    if (line_start_c) begin
      if (bus.vcount == 10'd0) begin
        state_d  = ST_IDLE;
        row_d    = '0;
        ty_d     = '0;
        synced_d = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (synced_q && bus.vcount == 10'(FIRST_ROW_V)) begin
              state_d = ST_BAND;
              ty_d    = '0;
            end
          end
          ST_BAND: begin
            if (ty_q == TY_W'(BAND_H - 1)) begin
              ty_d    = '0;
              state_d = (row_q == ROW_W'(NUM_ROWS - 1)) ? ST_DONE : ST_GAP;
            end else begin
              ty_d = ty_q + TY_W'(1);
            end
          end
          ST_GAP: begin
            if (ty_q == TY_W'(GAP_N - 1)) begin
              state_d = ST_BAND;
              row_d   = row_q + ROW_W'(1);
              ty_d    = '0;
            end else begin
              ty_d = ty_q + TY_W'(1);
            end
          end
          ST_DONE: ;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Shadow/active mask: a load on the commit cycle goes straight through.
  always_comb begin
    shadow_d = bus.mask_load ? bus.mask_data : shadow_q;
    active_d = frame_start_c ? shadow_d : active_q;
    pend_d   = pend_q;
    if (frame_start_c)      pend_d = 1'b0;
    else if (bus.mask_load) pend_d = 1'b1;
  end

  // Pixel pattern and two-stage output pipeline.
  always_comb begin
    in_win_c  = (bus.hcount >= 10'(H_START)) && (bus.hcount < 10'(H_END));
    tx_c      = CW'(TX_W'(bus.hcount - 10'(H_START)));
    pat_c     = ty_ok_c && ((ty_eff_c == '0) || (ty_eff_c == CW'(ROW_HEIGHT - 1)) ||
                            (tx_c == ty_eff_c) || (tx_c == CW'(TILE_W - 1) - ty_eff_c));
    s1_draw_d = (state_q == ST_BAND) && in_win_c && bus.bounds_draw && active_q[row_q] && pat_c;
    s1_row_d  = s1_draw_d ? row_q : '0;
    draw_d    = s1_draw_q;
    row_out_d = s1_row_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      ty_q      <= '0;
      synced_q  <= 1'b0;
      shadow_q  <= '1;
      active_q  <= '1;
      pend_q    <= 1'b0;
      s1_draw_q <= 1'b0;
      s1_row_q  <= '0;
      draw_q    <= 1'b0;
      row_out_q <= '0;
`ifdef MAP_SLOPE_EN
      sub_q     <= '0;
      off_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      ty_q      <= ty_d;
      synced_q  <= synced_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      s1_draw_q <= s1_draw_d;
      s1_row_q  <= s1_row_d;
      draw_q    <= draw_d;
      row_out_q <= row_out_d;
`ifdef MAP_SLOPE_EN
      sub_q     <= sub_d;
      off_q     <= off_d;
`endif
    end
  end

  assign bus.mask_pending = pend_q;
  assign bus.tile_draw    = draw_q;
  assign bus.tile_row     = row_out_q;

endmodule

// File: tb/tb_platform_map.sv
// Scoreboard bench for platform_map (default build): directed raster lines with hand-derived pixels.
module tb_platform_map;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   cur_fid = 0;

  platform_map_if #(.NUM_ROWS(6)) bus ();

  platform_map dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         at;
    bit         is_pend;
    logic       exp_d;
    logic [2:0] exp_r;
  } exp_t;

  typedef struct {
    int         f;
    int         h;
    int         v;
    logic       d;
    logic [2:0] r;
  } chk_t;

  exp_t sbq[$];
  chk_t chks[$];
  int   hl[9] = '{0, 149, 150, 155, 157, 160, 300, 629, 630};

  function automatic void add_chk(input int f, input int h, input int v,
                                  input logic d, input logic [2:0] r);
    chk_t c;
    c.f = f; c.h = h; c.v = v; c.d = d; c.r = r;
    chks.push_back(c);
  endfunction

  function automatic void push_draw(input string name, input logic d, input logic [2:0] r);
    exp_t e;
    e.name = name; e.at = cyc + 2; e.is_pend = 1'b0; e.exp_d = d; e.exp_r = r;
    sbq.push_back(e);
  endfunction

  function automatic void push_pend(input string name, input logic p);
    exp_t e;
    e.name = name; e.at = cyc + 1; e.is_pend = 1'b1; e.exp_d = p; e.exp_r = 3'd0;
    sbq.push_back(e);
  endfunction

  task automatic drive(input int h, input int v, input bit ld, input logic [5:0] md, input bit rst);
    @(posedge clk);
    #1;
    bus.hcount      = 10'(h);
    bus.vcount      = 10'(v);
    bus.bounds_draw = 1'b1;
    bus.mask_load   = ld;
    bus.mask_data   = md;
    rst_n           = !rst;
    foreach (chks[i]) begin
      if (chks[i].f == cur_fid && chks[i].h == h && chks[i].v == v)
        push_draw($sformatf("f%0d_h%0d_v%0d", cur_fid, h, v), chks[i].d, chks[i].r);
    end
  endtask

  task automatic do_line(input int v);
    bit ld0;
    bit chk0;
    ld0  = (cur_fid == 3 && v == 0);
    chk0 = ((cur_fid == 1 || cur_fid == 3) && v == 0);
    for (int i = 0; i < 9; i++) begin
      drive(hl[i], v, (i == 0) ? ld0 : 1'b0, 6'b111011, 1'b0);
      if (i == 0 && chk0) push_pend($sformatf("commit_f%0d", cur_fid), 1'b0);
    end
    if (cur_fid == 0 && v == 300) begin
      drive(700, v, 1'b1, 6'b000000, 1'b0);
      push_pend("load_first", 1'b1);
    end
    if (cur_fid == 0 && v == 305) begin
      drive(700, v, 1'b1, 6'b111110, 1'b0);
      push_pend("load_overwrite", 1'b1);
    end
    if (cur_fid == 0 && v == 330) begin
      drive(700, v, 1'b0, 6'b000000, 1'b0);
      push_pend("still_pending", 1'b1);
    end
    if (cur_fid == 2 && v == 320) begin
      drive(700, v, 1'b1, 6'b000001, 1'b0);
      push_pend("load_before_rst", 1'b1);
    end
    if (cur_fid == 2 && v == 330) begin
      drive(700, v, 1'b0, 6'b000000, 1'b1);
      push_pend("midframe_rst_pend", 1'b0);
      push_draw("midframe_rst_draw", 1'b0, 3'd0);
    end
  endtask

  task automatic run(input int fid, input int v0, input int v1);
    cur_fid = fid;
    for (int v = v0; v <= v1; v++) do_line(v);
  endtask

  // Monitor: compare every scoreboard entry on the cycle it falls due.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].at == cyc) begin
        total++;
        if (sbq[i].is_pend) begin
          if (bus.mask_pending !== sbq[i].exp_d) begin
            bad++;
            $display("FAIL %s: mask_pending=%b want %b", sbq[i].name, bus.mask_pending, sbq[i].exp_d);
          end
        end else if (bus.tile_draw !== sbq[i].exp_d || bus.tile_row !== sbq[i].exp_r) begin
          bad++;
          $display("FAIL %s: draw=%b row=%0d want draw=%b row=%0d", sbq[i].name,
                   bus.tile_draw, bus.tile_row, sbq[i].exp_d, sbq[i].exp_r);
        end
        sbq.delete(i);
      end else if (sbq[i].at < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: overdue at cycle %0d", sbq[i].name, cyc);
        sbq.delete(i);
      end
    end
  end

  initial begin
    // Frame 0: mask all ones, full geometry.
    add_chk(0, 150, 250, 1'b1, 3'd0);
    add_chk(0, 149, 250, 1'b0, 3'd0);
    add_chk(0, 630, 250, 1'b0, 3'd0);
    add_chk(0, 150, 249, 1'b0, 3'd0);
    add_chk(0, 155, 255, 1'b1, 3'd0);
    add_chk(0, 157, 255, 1'b0, 3'd0);
    add_chk(0, 160, 255, 1'b1, 3'd0);
    add_chk(0, 300, 259, 1'b1, 3'd0);
    add_chk(0, 150, 260, 1'b0, 3'd0);
    add_chk(0, 155, 275, 1'b0, 3'd0);
    add_chk(0, 150, 289, 1'b0, 3'd0);
    add_chk(0, 150, 290, 1'b1, 3'd1);
    add_chk(0, 629, 290, 1'b1, 3'd1);
    add_chk(0, 150, 330, 1'b1, 3'd2);
    add_chk(0, 150, 450, 1'b1, 3'd5);
    add_chk(0, 155, 459, 1'b1, 3'd5);
    add_chk(0, 150, 460, 1'b0, 3'd0);
    add_chk(0, 155, 465, 1'b0, 3'd0);
    add_chk(0, 150, 479, 1'b0, 3'd0);
    // Frame 1: committed mask 111110.
    add_chk(1, 150, 250, 1'b0, 3'd0);
    add_chk(1, 155, 255, 1'b0, 3'd0);
    add_chk(1, 150, 290, 1'b1, 3'd1);
    add_chk(1, 160, 295, 1'b1, 3'd1);
    // Frame 2: reset during line 330.
    add_chk(2, 150, 290, 1'b1, 3'd1);
    add_chk(2, 150, 330, 1'b1, 3'd2);
    add_chk(2, 150, 331, 1'b0, 3'd0);
    add_chk(2, 150, 370, 1'b0, 3'd0);
    add_chk(2, 150, 450, 1'b0, 3'd0);
    // Rewound lines after reset, before any vcount==0.
    add_chk(5, 150, 250, 1'b0, 3'd0);
    add_chk(5, 155, 255, 1'b0, 3'd0);
    // Frame 3: masks restored by reset, then 111011 loaded on the commit cycle.
    add_chk(3, 150, 250, 1'b1, 3'd0);
    add_chk(3, 155, 255, 1'b1, 3'd0);
    add_chk(3, 150, 290, 1'b1, 3'd1);
    add_chk(3, 150, 330, 1'b0, 3'd0);
    add_chk(3, 150, 370, 1'b1, 3'd3);

    rst_n           = 1'b0;
    bus.hcount      = '0;
    bus.vcount      = '0;
    bus.bounds_draw = 1'b0;
    bus.mask_load   = 1'b0;
    bus.mask_data   = '0;
    cur_fid         = 9;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1'b0, 6'b000000, 1'b1);
      push_pend("reset_pend", 1'b0);
      push_draw("reset_draw", 1'b0, 3'd0);
    end

    run(0, 0, 479);
    run(1, 0, 479);
    run(2, 0, 330);
    run(5, 250, 260);
    run(3, 0, 479);

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    foreach (sbq[i]) begin
      total++;
      bad++;
      $display("FAIL %s: never checked", sbq[i].name);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
